axil_arbiter: RTL

- Shares one AXI-Lite slave (e.g. the GPIO peripheral) between NUM_MASTERS AXI-Lite masters (CPU data port, debug/DMA).
- Independent write and read arbiters. Each uses round-robin grant and holds it until the full transaction completes (addr+data+resp).
- Sits between the master ports and the peripheral; no address decode, no buffering of payload. Payload is muxed straight through.

---
 rtl/axil_pkg.sv | 22 ++
 rtl/axil_arbiter_if.sv | 49 ++++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/axil_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite arbiter.
// Contents: AXI response codes and the write/read arbitration FSM state types.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WIdle,
    WAddr,
    WResp
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RAddr,
    RData
  } r_state_e;

endpackage

// File: rtl/axil_arbiter_if.sv
// AXI-Lite signal bundle carrying N_PORTS parallel links (packed per-port arrays).
// Used with N_PORTS = NUM_MASTERS for the upstream side and N_PORTS = 1 for the
// downstream side.
//   modport master : drives AW/W/AR payload+valid, bready, rready
//   modport slave  : drives awready, wready, arready, B and R channels
interface axil_arbiter_if #(
  parameter int unsigned N_PORTS    = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] awaddr;
  logic [N_PORTS-1:0][2:0]            awprot;
  logic [N_PORTS-1:0]                 awvalid;
  logic [N_PORTS-1:0]                 awready;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] wdata;
  logic [N_PORTS-1:0][STRB_WIDTH-1:0] wstrb;
  logic [N_PORTS-1:0]                 wvalid;
  logic [N_PORTS-1:0]                 wready;
  logic [N_PORTS-1:0][1:0]            bresp;
  logic [N_PORTS-1:0]                 bvalid;
  logic [N_PORTS-1:0]                 bready;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] araddr;
  logic [N_PORTS-1:0][2:0]            arprot;
  logic [N_PORTS-1:0]                 arvalid;
  logic [N_PORTS-1:0]                 arready;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic [N_PORTS-1:0][1:0]            rresp;
  logic [N_PORTS-1:0]                 rvalid;
  logic [N_PORTS-1:0]                 rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin requester picker with registered priority pointer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   adv_i         : 1-cycle strobe, moves pointer to one past gnt_idx_i
//   gnt_idx_i     : index of the requester just served
//   pick_idx_o    : combinational pick (first request at/after pointer)
//   pick_valid_o  : any request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 adv_i,
  input  logic [IDX_WIDTH-1:0] gnt_idx_i,
  output logic [IDX_WIDTH-1:0] pick_idx_o,
  output logic                 pick_valid_o
);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      // Explicit wrap so non-power-of-two requester counts work.
      ptr_d = (gnt_idx_i == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx_i + 1'b1;
    end
  end

  always_comb begin
    int unsigned k;
    k            = 0;
    pick_valid_o = 1'b0;
    pick_idx_o   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = i + 32'(ptr_q);
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!pick_valid_o && req_i[IDX_WIDTH'(k)]) begin
        pick_valid_o = 1'b1;
        pick_idx_o   = IDX_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axil_arbiter.sv
// Shares one AXI-Lite slave between NUM_MASTERS AXI-Lite masters.
// Independent round-robin write and read arbiters; a grant is held until the
// whole transaction (address, data, response) completes. Payload is muxed
// straight through, nothing is buffered.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   s_bus    : upstream master links (slave modport, NUM_MASTERS wide)
//   m_bus    : downstream slave link (master modport, single)
//   w_gnt    : one-hot write grant, 0 when the write FSM is idle
//   r_gnt    : one-hot read grant, 0 when the read FSM is idle
module axil_arbiter
  import axil_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  axil_arbiter_if.slave          s_bus,
  axil_arbiter_if.master         m_bus,
  output logic [NUM_MASTERS-1:0] w_gnt,
  output logic [NUM_MASTERS-1:0] r_gnt
);

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e             w_state_q, w_state_d;
  logic [IDX_WIDTH-1:0] w_idx_q, w_idx_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 w_adv;
  logic                 aw_hs, w_hs;
  logic [IDX_WIDTH-1:0] w_pick_idx;
  logic                 w_pick_valid;

  logic [ADDR_WIDTH-1:0] awaddr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [STRB_WIDTH-1:0] wstrb_sel;

  assign awaddr_sel = s_bus.awaddr[w_idx_q];
  assign wdata_sel  = s_bus.wdata[w_idx_q];
  assign wstrb_sel  = s_bus.wstrb[w_idx_q];

  rr_arbiter #(
    .NUM_REQ  (NUM_MASTERS),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_w_rr (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (s_bus.awvalid),
    .adv_i       (w_adv),
    .gnt_idx_i   (w_idx_q),
    .pick_idx_o  (w_pick_idx),
    .pick_valid_o(w_pick_valid)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_adv     = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    m_bus.awaddr  = '0;
    m_bus.awprot  = '0;
    m_bus.awvalid = '0;
    m_bus.wdata   = '0;
    m_bus.wstrb   = '0;
    m_bus.wvalid  = '0;
    m_bus.bready  = '0;
    s_bus.awready = '0;
    s_bus.wready  = '0;
    s_bus.bvalid  = '0;
    s_bus.bresp   = '0;

    unique case (w_state_q)
      WIdle: begin
        if (w_pick_valid) begin
          w_idx_d   = w_pick_idx;
          w_state_d = WAddr;
        end
      end
      WAddr: begin
        m_bus.awaddr[0]        = awaddr_sel;
        m_bus.awprot[0]        = s_bus.awprot[w_idx_q];
        m_bus.awvalid[0]       = s_bus.awvalid[w_idx_q] & ~aw_done_q;
        s_bus.awready[w_idx_q] = m_bus.awready[0] & ~aw_done_q;
        m_bus.wdata[0]         = wdata_sel;
        m_bus.wstrb[0]         = wstrb_sel;
        m_bus.wvalid[0]        = s_bus.wvalid[w_idx_q] & ~w_done_q;
        s_bus.wready[w_idx_q]  = m_bus.wready[0] & ~w_done_q;

        aw_hs     = s_bus.awvalid[w_idx_q] & m_bus.awready[0] & ~aw_done_q;
        w_hs      = s_bus.wvalid[w_idx_q] & m_bus.wready[0] & ~w_done_q;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        // AW and W may finish in either order or together.
        if (aw_done_d && w_done_d) w_state_d = WResp;
      end
      WResp: begin
        m_bus.bready[0]       = s_bus.bready[w_idx_q];
        s_bus.bvalid[w_idx_q] = m_bus.bvalid[0];
        s_bus.bresp[w_idx_q]  = m_bus.bresp[0];
        if (m_bus.bvalid[0] && s_bus.bready[w_idx_q]) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_adv     = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= WIdle;
      w_idx_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_state_q != WIdle) w_gnt[w_idx_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e             r_state_q, r_state_d;
  logic [IDX_WIDTH-1:0] r_idx_q, r_idx_d;
  logic                 r_adv;
  logic [IDX_WIDTH-1:0] r_pick_idx;
  logic                 r_pick_valid;

  logic [ADDR_WIDTH-1:0] araddr_sel;

  assign araddr_sel = s_bus.araddr[r_idx_q];

  rr_arbiter #(
    .NUM_REQ  (NUM_MASTERS),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_r_rr (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (s_bus.arvalid),
    .adv_i       (r_adv),
    .gnt_idx_i   (r_idx_q),
    .pick_idx_o  (r_pick_idx),
    .pick_valid_o(r_pick_valid)
  );

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_adv     = 1'b0;

    m_bus.araddr  = '0;
    m_bus.arprot  = '0;
    m_bus.arvalid = '0;
    m_bus.rready  = '0;
    s_bus.arready = '0;
    s_bus.rvalid  = '0;
    s_bus.rdata   = '0;
    s_bus.rresp   = '0;

    unique case (r_state_q)
      RIdle: begin
        if (r_pick_valid) begin
          r_idx_d   = r_pick_idx;
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        m_bus.araddr[0]        = araddr_sel;
        m_bus.arprot[0]        = s_bus.arprot[r_idx_q];
        m_bus.arvalid[0]       = s_bus.arvalid[r_idx_q];
        s_bus.arready[r_idx_q] = m_bus.arready[0];
        if (s_bus.arvalid[r_idx_q] && m_bus.arready[0]) r_state_d = RData;
      end
      RData: begin
        m_bus.rready[0]       = s_bus.rready[r_idx_q];
        s_bus.rvalid[r_idx_q] = m_bus.rvalid[0];
        s_bus.rdata[r_idx_q]  = m_bus.rdata[0];
        s_bus.rresp[r_idx_q]  = m_bus.rresp[0];
        if (m_bus.rvalid[0] && s_bus.rready[r_idx_q]) begin
          r_adv     = 1'b1;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= RIdle;
      r_idx_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
    end
  end

  always_comb begin
    r_gnt = '0;
    if (r_state_q != RIdle) r_gnt[r_idx_q] = 1'b1;
  end

endmodule
